// File: rtl/wb_stage_pipe.sv
// Registered MEM/WB write-back stage: holds one entry, selects the result source,
// extracts load data, waits for late load responses with a timeout, counts retires.
module wb_stage_pipe #(
  parameter int XLEN       = 32,
  parameter int REG_AW     = 5,
  parameter int LD_TIMEOUT = 16,
  parameter int CNT_W      = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_wb_sel,
  input  logic              in_wb_en,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [XLEN-1:0]   in_opr_res,
  input  logic [XLEN-1:0]   in_pc4,
  input  logic [XLEN-1:0]   in_csr_rd,
  input  logic [2:0]        in_funct3,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              flush,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              load_err,
  output logic              busy,
  output logic [CNT_W-1:0]  instret
);

  localparam int TW = $clog2(LD_TIMEOUT + 1);

  typedef enum logic [1:0] {EMPTY, HOLD, WAIT_LD} state_t;

  state_t              state;
  logic [TW-1:0]       timer;
  logic                h_wb_en;
  logic [REG_AW-1:0]   h_rd;
  logic [XLEN-1:0]     h_data;
  logic [1:0]          h_addr;
  logic [2:0]          h_f3;

  logic                commit;
  logic                timeout;
  logic                accept;
  logic [XLEN-1:0]     sel_data;
  logic [XLEN-1:0]     ld_data;

  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] w,
                                              input logic [1:0] a,
                                              input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] wd;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h  = a[1] ? w[31:16] : w[15:0];
    wd = w[31:0];
    case (f3)
      3'b000:  extract = XLEN'($signed(b));
      3'b001:  extract = XLEN'($signed(h));
      3'b010:  extract = XLEN'($signed(wd));
      3'b100:  extract = XLEN'(b);
      3'b101:  extract = XLEN'(h);
      default: extract = '0;
    endcase
  endfunction

  // Flush dominates everything; rvalid in the last wait cycle beats the timeout.
  always_comb begin
    commit   = !flush && ((state == HOLD) || (state == WAIT_LD && dmem_rvalid));
    timeout  = !flush && (state == WAIT_LD) && !dmem_rvalid &&
               (timer == TW'(LD_TIMEOUT - 1));
    in_ready = (state == EMPTY) || commit || timeout || flush;
    accept   = in_valid && in_ready && !flush;
    ld_data  = extract(dmem_rdata, h_addr, h_f3);
    case (in_wb_sel)
      2'b10:   sel_data = in_pc4;
      2'b11:   sel_data = in_csr_rd;
      default: sel_data = in_opr_res;
    endcase
    rf_we    = commit && h_wb_en && (h_rd != '0);
    rf_waddr = rf_we ? h_rd : '0;
    rf_wdata = '0;
    if (rf_we) rf_wdata = (state == WAIT_LD) ? ld_data : h_data;
    load_err = timeout;
    busy     = (state == WAIT_LD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      timer   <= '0;
      h_wb_en <= 1'b0;
      h_rd    <= '0;
      h_data  <= '0;
      h_addr  <= '0;
      h_f3    <= '0;
      instret <= '0;
    end else begin
      if (commit) instret <= instret + CNT_W'(1);
      if (accept) begin
        state   <= (in_wb_sel == 2'b01) ? WAIT_LD : HOLD;
        timer   <= '0;
        h_wb_en <= in_wb_en;
        h_rd    <= in_rd;
        h_data  <= sel_data;
        h_addr  <= in_opr_res[1:0];
        h_f3    <= in_funct3;
      end else if (flush || commit || timeout) begin
        state <= EMPTY;
      end else if (state == WAIT_LD) begin
        timer <= timer + TW'(1);
      end
    end
  end

endmodule
